if_fetch: RTL and testbench

Instruction-fetch stage for the five-stage CPU. It owns the program counter and drives the chip-enable and byte address of the combinational instruction ROM. It registers the returned instruction word and its PC into the IF/ID boundary. It also handles pipeline stall, delayed branch/jump redirection, and exception flush.

---
 rtl/if_fetch_pkg.sv | 23 ++
 rtl/if_id_reg.sv | 60 ++++++
 rtl/if_fetch.sv | 124 ++++++++++++
 tb/tb_if_fetch.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_pkg
// Brief    : Shared constants, bus widths and FSM encoding for the fetch stage.
// Revision : 1.0
// ============================================================================
package if_fetch_pkg;

    localparam logic        ChipEnable  = 1'b1;
    localparam logic        ChipDisable = 1'b0;
    localparam int          InstAddrBus = 32;
    localparam int          InstBus     = 32;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic [31:0] c_pc_inc    = 32'd4;

    typedef enum logic [1:0] {
        FETCH_BOOT = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Brief    : IF/ID pipeline register with stall hold and bubble insertion.
// Revision : 1.0
// ============================================================================
module if_id_reg
    import if_fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              fetch_ce,
    input  logic              fetch_excp,
    input  logic [ADDR_W-1:0] fetch_pc,
    input  logic [INST_W-1:0] fetch_inst,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic              id_valid,
    output logic              id_excp
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_pc    <= '0;
            id_inst  <= INST_W'(ZeroWord);
            id_valid <= 1'b0;
            id_excp  <= 1'b0;
        end else if (flush) begin
            id_pc    <= '0;
            id_inst  <= INST_W'(ZeroWord);
            id_valid <= 1'b0;
            id_excp  <= 1'b0;
        end else if (!stall) begin
            if (fetch_excp) begin
                // Faulting fetch keeps its PC so the later stage can report it
                id_pc    <= fetch_pc;
                id_inst  <= INST_W'(ZeroWord);
                id_valid <= 1'b1;
                id_excp  <= 1'b1;
            end else if (fetch_ce == ChipEnable) begin
                id_pc    <= fetch_pc;
                id_inst  <= fetch_inst;
                id_valid <= 1'b1;
                id_excp  <= 1'b0;
            end else begin
                id_pc    <= '0;
                id_inst  <= INST_W'(ZeroWord);
                id_valid <= 1'b0;
                id_excp  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Brief    : Instruction fetch: PC, ROM interface, stall/branch/flush handling.
//            Optional alignment check enabled by defining IF_ALIGN_CHECK_EN.
// Revision : 1.0
// ============================================================================
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32,
    parameter int          INST_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] new_pc_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [INST_W-1:0] rom_inst_i,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic              id_valid_o,
    output logic              if_excp_o
);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_ce;
    logic              r_pend_flag;
    logic [ADDR_W-1:0] r_pend_target;

    logic              w_booting;
    logic              w_flush;
    logic              w_misaligned;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_next_ok;
    logic              w_new_ok;
    logic              w_boot_ok;

    assign w_booting = (r_state == FETCH_BOOT);
    assign w_flush   = flush_i && !w_booting;
    assign w_next_pc = branch_flag_i ? branch_target_i :
                       r_pend_flag   ? r_pend_target   :
                                       r_pc + ADDR_W'(c_pc_inc);

`ifdef IF_ALIGN_CHECK_EN
    assign w_misaligned = !w_booting && (r_pc[1:0] != 2'b00);
    assign w_next_ok    = (w_next_pc[1:0] == 2'b00);
    assign w_new_ok     = (new_pc_i[1:0] == 2'b00);
    assign w_boot_ok    = (RESET_PC[1:0] == 2'b00);
`else
    assign w_misaligned = 1'b0;
    assign w_next_ok    = ChipEnable;
    assign w_new_ok     = ChipEnable;
    assign w_boot_ok    = ChipEnable;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= FETCH_BOOT;
            r_pc          <= ADDR_W'(RESET_PC);
            r_ce          <= ChipDisable;
            r_pend_flag   <= 1'b0;
            r_pend_target <= '0;
        end else begin
            case (r_state)
                FETCH_BOOT: begin
                    r_state <= FETCH_RUN;
                    r_ce    <= w_boot_ok;
                end
                default: begin
                    if (w_flush) begin
                        r_state     <= FETCH_RUN;
                        r_pc        <= new_pc_i;
                        r_ce        <= w_new_ok;
                        r_pend_flag <= 1'b0;
                    end else if (stall_i) begin
                        r_state <= FETCH_HOLD;
                        if (branch_flag_i) begin
                            r_pend_flag   <= 1'b1;
                            r_pend_target <= branch_target_i;
                        end
                    end else begin
                        r_state     <= FETCH_RUN;
                        r_pend_flag <= 1'b0;
                        // A faulting PC stays put until a flush redirects it
                        if (!w_misaligned) begin
                            r_pc <= w_next_pc;
                            r_ce <= w_next_ok;
                        end
                    end
                end
            endcase
        end
    end

    assign rom_ce_o   = r_ce;
    assign rom_addr_o = r_pc;

    if_id_reg #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall_i && !w_booting),
        .flush      (w_flush),
        .fetch_ce   (r_ce),
        .fetch_excp (w_misaligned),
        .fetch_pc   (r_pc),
        .fetch_inst (rom_inst_i),
        .id_pc      (id_pc_o),
        .id_inst    (id_inst_o),
        .id_valid   (id_valid_o),
        .id_excp    (if_excp_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch
// Brief    : Self-checking bench for if_fetch with a cycle-level reference model.
// Revision : 1.0
// ============================================================================
module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, branch;
    logic [31:0] new_pc, target;
    logic        rom_ce;
    logic [31:0] rom_addr, rom_inst;
    logic [31:0] id_pc, id_inst;
    logic        id_valid, if_excp;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit          m_boot;
    logic [31:0] m_pc;
    bit          m_ce;
    bit          m_pend;
    logic [31:0] m_ptgt;
    logic [31:0] m_id_pc, m_id_inst;
    bit          m_id_valid, m_excp;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic bit addr_ok(input logic [31:0] a);
`ifdef IF_ALIGN_CHECK_EN
        return a[1:0] == 2'b00;
`else
        return 1'b1;
`endif
    endfunction

    // Data is poisoned when the ROM is disabled so leakage shows up
    assign rom_inst = rom_ce ? rom_word(rom_addr) : 32'hDEAD_BEEF;

    if_fetch #(
        .RESET_PC (RESET_PC),
        .ADDR_W   (32),
        .INST_W   (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall),
        .flush_i         (flush),
        .new_pc_i        (new_pc),
        .branch_flag_i   (branch),
        .branch_target_i (target),
        .rom_ce_o        (rom_ce),
        .rom_addr_o      (rom_addr),
        .rom_inst_i      (rom_inst),
        .id_pc_o         (id_pc),
        .id_inst_o       (id_inst),
        .id_valid_o      (id_valid),
        .if_excp_o       (if_excp)
    );

    task automatic model_reset();
        m_boot = 1; m_pc = RESET_PC; m_ce = 0; m_pend = 0; m_ptgt = 0;
        m_id_pc = 0; m_id_inst = 0; m_id_valid = 0; m_excp = 0;
    endtask

    task automatic set_bubble();
        m_id_pc = 0; m_id_inst = 0; m_id_valid = 0; m_excp = 0;
    endtask

    // One clock edge of the fetch rules, evaluated with the current inputs
    task automatic model_step();
        logic [31:0] nxt;
        if (m_boot) begin
            m_boot = 0;
            m_ce   = addr_ok(m_pc);
            set_bubble();
        end else if (flush) begin
            set_bubble();
            m_pc = new_pc; m_ce = addr_ok(new_pc); m_pend = 0;
        end else if (stall) begin
            if (branch) begin m_pend = 1; m_ptgt = target; end
        end else begin
            if (!addr_ok(m_pc)) begin
                m_id_pc = m_pc; m_id_inst = 0; m_id_valid = 1; m_excp = 1;
            end else begin
                if (m_ce) begin
                    m_id_pc = m_pc; m_id_inst = rom_word(m_pc); m_id_valid = 1; m_excp = 0;
                end else begin
                    set_bubble();
                end
                nxt  = branch ? target : (m_pend ? m_ptgt : m_pc + 32'd4);
                m_pc = nxt; m_ce = addr_ok(nxt);
            end
            m_pend = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; branch = 0; new_pc = 0; target = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs(); model_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++; if (rom_ce !== 1'b0) begin fails++; $display("FAIL reset_ce got %b want 0", rom_ce); end
        tests++; if (rom_addr !== RESET_PC) begin fails++; $display("FAIL reset_addr got %h want %h", rom_addr, RESET_PC); end
        tests++; if ({id_pc, id_inst, id_valid, if_excp} !== 66'd0) begin fails++;
            $display("FAIL reset_ifid got pc=%h inst=%h v=%b e=%b want zeros", id_pc, id_inst, id_valid, if_excp); end
        rst = 0;
        tick();
        tests++; if (rom_ce !== 1'b1 || rom_addr !== 32'h0 || id_valid !== 1'b0) begin fails++;
            $display("FAIL boot_exit got ce=%b addr=%h v=%b want 1/0/0", rom_ce, rom_addr, id_valid); end
        tick();
        tests++; if (rom_addr !== 32'h4 || id_pc !== 32'h0 || id_inst !== rom_word(32'h0) || id_valid !== 1'b1) begin fails++;
            $display("FAIL first_fetch got addr=%h pc=%h inst=%h v=%b", rom_addr, id_pc, id_inst, id_valid); end
        tick();
        tests++; if (rom_addr !== 32'h8 || id_inst !== rom_word(32'h4)) begin fails++;
            $display("FAIL second_fetch got addr=%h inst=%h want 8/%h", rom_addr, id_inst, rom_word(32'h4)); end
    endtask

    task automatic test_branch();
        tick();
        tests++; if (id_pc !== 32'h8 || rom_addr !== 32'hC) begin fails++;
            $display("FAIL pre_branch got id_pc=%h addr=%h want 8/c", id_pc, rom_addr); end
        branch = 1; target = 32'h40;
        tick();
        branch = 0;
        tests++; if (id_pc !== 32'hC || rom_addr !== 32'h40) begin fails++;
            $display("FAIL delay_slot got id_pc=%h addr=%h want c/40", id_pc, rom_addr); end
        tick();
        tests++; if (id_pc !== 32'h40 || id_inst !== rom_word(32'h40) || rom_addr !== 32'h44) begin fails++;
            $display("FAIL branch_target got id_pc=%h inst=%h addr=%h", id_pc, id_inst, rom_addr); end
    endtask

    task automatic test_stall_branch();
        flush = 1; new_pc = 32'h10;
        tick();
        flush = 0;
        tests++; if (rom_addr !== 32'h10 || id_valid !== 1'b0) begin fails++;
            $display("FAIL flush_to_10 got addr=%h v=%b", rom_addr, id_valid); end
        tick();
        tests++; if (rom_addr !== 32'h14 || id_pc !== 32'h10) begin fails++;
            $display("FAIL run_10 got addr=%h id_pc=%h want 14/10", rom_addr, id_pc); end
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin branch = 1; target = 32'h80; end
            tick();
            branch = 0;
            tests++; if (rom_addr !== 32'h14 || id_pc !== 32'h10 || id_inst !== rom_word(32'h10) || id_valid !== 1'b1) begin fails++;
                $display("FAIL stall_freeze%0d got addr=%h id_pc=%h v=%b", i, rom_addr, id_pc, id_valid); end
        end
        stall = 0;
        tick();
        tests++; if (rom_addr !== 32'h80 || id_pc !== 32'h14) begin fails++;
            $display("FAIL pending_branch got addr=%h id_pc=%h want 80/14", rom_addr, id_pc); end
        tick();
        tests++; if (rom_addr !== 32'h84 || id_pc !== 32'h80) begin fails++;
            $display("FAIL pending_cleared got addr=%h id_pc=%h want 84/80", rom_addr, id_pc); end
    endtask

    task automatic test_flush_stall();
        stall = 1; branch = 1; target = 32'h200;
        tick();
        branch = 0; flush = 1; new_pc = 32'h180;
        tick();
        flush = 0;
        tests++; if (rom_addr !== 32'h180 || id_valid !== 1'b0 || id_pc !== 32'h0) begin fails++;
            $display("FAIL flush_in_stall got addr=%h v=%b pc=%h want 180/0/0", rom_addr, id_valid, id_pc); end
        stall = 0;
        tick();
        tests++; if (rom_addr !== 32'h184 || id_pc !== 32'h180) begin fails++;
            $display("FAIL pending_discard got addr=%h id_pc=%h want 184/180", rom_addr, id_pc); end
    endtask

    task automatic test_wrap();
        flush = 1; new_pc = 32'hFFFF_FFFC;
        tick();
        flush = 0;
        tick();
        tests++; if (rom_addr !== 32'h0 || id_pc !== 32'hFFFF_FFFC) begin fails++;
            $display("FAIL pc_wrap got addr=%h id_pc=%h want 0/fffffffc", rom_addr, id_pc); end
    endtask

`ifdef IF_ALIGN_CHECK_EN
    task automatic test_align();
        branch = 1; target = 32'h42;
        tick();
        branch = 0;
        tests++; if (rom_addr !== 32'h42 || rom_ce !== 1'b0) begin fails++;
            $display("FAIL align_ce got addr=%h ce=%b want 42/0", rom_addr, rom_ce); end
        repeat (2) tick();
        tests++; if (if_excp !== 1'b1 || id_pc !== 32'h42 || id_inst !== 32'h0 || id_valid !== 1'b1 || rom_addr !== 32'h42) begin fails++;
            $display("FAIL align_excp got e=%b id_pc=%h inst=%h v=%b addr=%h", if_excp, id_pc, id_inst, id_valid, rom_addr); end
        flush = 1; new_pc = 32'h180;
        tick();
        flush = 0;
        tests++; if (rom_addr !== 32'h180 || rom_ce !== 1'b1 || if_excp !== 1'b0) begin fails++;
            $display("FAIL align_flush got addr=%h ce=%b e=%b", rom_addr, rom_ce, if_excp); end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            stall  = ($urandom_range(0, 9) < 3);
            branch = ($urandom_range(0, 9) < 2);
            flush  = ($urandom_range(0, 19) == 0);
            target = $urandom & 32'hFFFF_FFFC;
            new_pc = $urandom & 32'hFFFF_FFFC;
`ifdef IF_ALIGN_CHECK_EN
            if ($urandom_range(0, 7) == 0) target[1:0] = 2'b10;
`endif
            tick();
            tests++;
            if ({rom_ce, rom_addr, id_pc, id_inst, id_valid, if_excp} !==
                {m_ce, m_pc, m_id_pc, m_id_inst, m_id_valid, m_excp}) begin
                fails++;
                $display("FAIL random[%0d] got ce=%b addr=%h pc=%h inst=%h v=%b e=%b want ce=%b addr=%h pc=%h inst=%h v=%b e=%b",
                         i, rom_ce, rom_addr, id_pc, id_inst, id_valid, if_excp,
                         m_ce, m_pc, m_id_pc, m_id_inst, m_id_valid, m_excp);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_midop();
        repeat (3) tick();
        @(posedge clk);
        #3;
        rst = 1;
        #1;
        tests++; if ({rom_ce, rom_addr, id_pc, id_inst, id_valid, if_excp} !== {1'b0, RESET_PC, 66'd0}) begin fails++;
            $display("FAIL async_reset got ce=%b addr=%h pc=%h inst=%h v=%b", rom_ce, rom_addr, id_pc, id_inst, id_valid); end
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if ({rom_ce, rom_addr, id_pc, id_inst, id_valid} !== {m_ce, m_pc, m_id_pc, m_id_inst, m_id_valid}) begin
                fails++;
                $display("FAIL restart[%0d] got ce=%b addr=%h pc=%h v=%b want ce=%b addr=%h pc=%h v=%b",
                         i, rom_ce, rom_addr, id_pc, id_valid, m_ce, m_pc, m_id_pc, m_id_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_stall_branch();
        test_flush_stall();
        test_wrap();
`ifdef IF_ALIGN_CHECK_EN
        test_align();
`endif
        test_random();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
